// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operation split into STAGES chunks,
// one chunk resolved per stage with the carry registered between stages.
// Global stall: every stage holds while the output is valid and not taken.
// Optional macro PIPELINED_ADDER_OVF_EN adds a registered signed-overflow
// output (out_ovf) aligned with out_sum.
`default_nettype none

module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtract is A + ~B + 1; in_cin only matters in add mode.
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign cin_eff  = in_sub | in_cin;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall & ~rst;

  // Stage k register q packs {pending B, pending A, resolved sum}; the pending
  // fields shrink by one chunk per stage, so the final stage holds only the sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;
    localparam int QW  = 2 * WIDTH - (k + 1) * CHUNK;

    logic [QW-1:0]    q;
    logic [QW-1:0]    q_d;
    logic             v;
    logic             c;
    logic             v_in;
    logic             c_in;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   add;

    assign add = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_first
      assign v_in = in_valid;
      assign c_in = cin_eff;
      assign a_ch = in_a[CHUNK-1:0];
      assign b_ch = b_eff[CHUNK-1:0];
      if (STAGES == 1) begin : g_only
        assign q_d = add[CHUNK-1:0];
      end else begin : g_fwd
        assign q_d = {b_eff[WIDTH-1:CHUNK], in_a[WIDTH-1:CHUNK], add[CHUNK-1:0]};
      end
    end else begin : g_next
      logic [LO-1:0]  sum_prev;
      logic [REM-1:0] a_prev;
      logic [REM-1:0] b_prev;
      assign sum_prev = g_stage[k-1].q[LO-1:0];
      assign a_prev   = g_stage[k-1].q[LO +: REM];
      assign b_prev   = g_stage[k-1].q[LO+REM +: REM];
      assign v_in     = g_stage[k-1].v;
      assign c_in     = g_stage[k-1].c;
      assign a_ch     = a_prev[CHUNK-1:0];
      assign b_ch     = b_prev[CHUNK-1:0];
      if (k == STAGES - 1) begin : g_last
        assign q_d = {add[CHUNK-1:0], sum_prev};
      end else begin : g_fwd
        assign q_d = {b_prev[REM-1:CHUNK], a_prev[REM-1:CHUNK], add[CHUNK-1:0], sum_prev};
      end
    end

    // Stage register: advances with the whole pipe, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
        q <= '0;
      end else if (adv) begin
        v <= v_in;
        c <= add[CHUNK];
        q <= q_d;
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign out_valid = v;
      assign out_sum   = q;
      assign out_cout  = c;
`ifdef PIPELINED_ADDER_OVF_EN
      logic ovf_q;
      logic ovf_d;
      // Carry into the MSB is recovered from the MSB sum bit and operand bits.
      assign ovf_d = add[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ add[CHUNK];
      // Overflow flag travels with the final-stage result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end
      assign out_ovf = ovf_q;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases plus random traffic
// against a transaction-level latency/stall model.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         out_ovf;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: S slots, a result reaches the last slot S accepted cycles later;
  // the whole line freezes while the last slot is valid and out_ready=0.
  bit           m_v [S];
  logic [W-1:0] m_s [S];
  bit           m_c [S];
  bit           m_o [S];
  int           n_acc = 0;
  int           n_emit = 0;
  int           cyc = 0;
  logic [W-1:0] q_emit [$];
  int           q_cyc  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub,
                                 output logic [W-1:0] s, output bit c, output bit o);
    logic [W:0] t;
    if (sub) begin
      t = {1'b0, a} - {1'b0, b};
      s = t[W-1:0];
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s = t[W-1:0];
      c = t[W];
      o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < S; i++) begin
      m_v[i] = 0; m_s[i] = '0; m_c[i] = 0; m_o[i] = 0;
    end
  endtask

  // One clock: check in_ready, take the edge, update the model, check outputs.
  task automatic tick();
    bit stall;
    #1;
    stall = m_v[S-1] && !out_ready;
    chk("in_ready", in_ready, !stall);
    @(posedge clk);
    cyc++;
    if (!stall) begin
      if (m_v[S-1]) begin
        n_emit++;
        q_emit.push_back(m_s[S-1]);
        q_cyc.push_back(cyc);
      end
      for (int i = S - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_s[i] = m_s[i-1]; m_c[i] = m_c[i-1]; m_o[i] = m_o[i-1];
      end
      m_v[0] = in_valid;
      if (in_valid) begin
        n_acc++;
        ref_op(in_a, in_b, in_cin, in_sub, m_s[0], m_c[0], m_o[0]);
      end
    end
    #1;
    chk("out_valid", out_valid, m_v[S-1]);
    if (m_v[S-1]) begin
      chk("out_sum", out_sum, m_s[S-1]);
      chk("out_cout", out_cout, m_c[S-1]);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("out_ovf", out_ovf, m_o[S-1]);
`endif
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit cin, input bit sub);
    in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
  endtask

  // Single op on an empty pipe, with latency and constant result checks.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input bit sub,
                         input logic [W-1:0] es, input bit ec, input bit eo);
    int n;
    out_ready = 1'b1;
    drive(1, a, b, cin, sub);
    tick();
    drive(0, '0, '0, 0, 0);
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, S);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, out_cout, ec);
`ifdef PIPELINED_ADDER_OVF_EN
    chk({tag, "_ovf"}, out_ovf, eo);
`else
    if (eo) n = n + 0;
`endif
    tick();
  endtask

  initial begin
    int e0;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, '0, '0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", out_cout, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("rst_out_ovf", out_ovf, 1'b0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed arithmetic
    run_one("add_basic", 32'd1, 32'd0, 1, 0, 32'd2, 0, 0);
    run_one("ripple", 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1, 0);
    run_one("sub_borrow", 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0);
    run_one("sub_noborrow", 32'd7, 32'd5, 0, 1, 32'd2, 1, 0);
    run_one("ovf_add", 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 1);
    run_one("ovf_sub", 32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 1, 1);
    run_one("no_ovf", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0);

    // Streaming, no bubble
    q_emit.delete(); q_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1, k, k + 1, 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0);
    for (int i = 0; i < S + 2; i++) tick();
    chk("stream_count", q_emit.size(), 6);
    for (int i = 0; i < q_emit.size() && i < 6; i++) begin
      chk("stream_sum", q_emit[i], 2 * i + 1);
      if (i > 0) chk("stream_gap", q_cyc[i] - q_cyc[i-1], 1);
    end

    // Streaming with one bubble after the third op
    q_emit.delete(); q_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        drive(0, '0, '0, 0, 0);
        tick();
      end
      drive(1, k, k + 1, 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0);
    for (int i = 0; i < S + 2; i++) tick();
    chk("bubble_count", q_emit.size(), 6);
    for (int i = 0; i < q_emit.size() && i < 6; i++) begin
      chk("bubble_sum", q_emit[i], 2 * i + 1);
      if (i > 0) chk("bubble_gap", q_cyc[i] - q_cyc[i-1], (i == 3) ? 2 : 1);
    end

    // Fill, stall 3 cycles with junk offered, then drain
    for (int k = 0; k < S; k++) begin
      drive(1, 32'h100 * (k + 1), 32'h11, 0, 0);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hDEAD_0000 + i, 32'h1, 1, 0);
      tick();
      chk("stall_hold_sum", out_sum, 32'h111);
    end
    out_ready = 1'b1;
    drive(0, '0, '0, 0, 0);
    e0 = n_emit;
    for (int i = 0; i < S + 4; i++) tick();
    chk("stall_drain_count", n_emit - e0, S);

    // Asynchronous reset with two ops in flight
    drive(1, 32'h1234, 32'h1111, 0, 0);
    tick();
    drive(1, 32'h5678, 32'h2222, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_sum", out_sum, '0);
    chk("arst_out_cout", out_cout, 1'b0);
    model_clear();
    #2;
    rst = 1'b0;
    e0 = n_emit;
    for (int i = 0; i < S + 4; i++) tick();
    chk("arst_no_emit", n_emit - e0, 0);

    // Random traffic with random backpressure
    n_acc = 0;
    n_emit = 0;
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
      drive($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 1), $urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drive(0, '0, '0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < S + 2; i++) tick();
    chk("rand_in_out_count", n_emit, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit. It is the multi-cycle, wide-word successor of the team's single-bit full adder.
- The WIDTH-bit operation is split into STAGES chunks. One chunk is resolved per pipeline stage, with the carry registered between stages.
- A valid/ready handshake on both sides lets it sit in streaming datapaths.
- Sustains one operation per cycle when the output side is not stalled.

Parameters:
- WIDTH, 32: operand/result width in bits.
- STAGES, 4: pipeline depth and chunk count. WIDTH mod STAGES must be 0; CHUNK = WIDTH/STAGES. STAGES=1 is legal (single registered stage).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  pipeline can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add mode only)
- in_sub  input  1  1 = A - B, 0 = A + B + cin
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry-out of MSB chunk

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset values:
  - out_valid=0, out_sum=0, out_cout=0.
  - All stage valid bits, carries and partial-result registers are 0.
  - in_ready is 1 while rst is deasserted and the pipe is empty.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronously). Nothing is emitted after release until new inputs are accepted.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge.
- Stall rule: global stall, stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every stage register holds, including outputs, which stay stable.
  - in_valid while in_ready=0 is ignored.
- Subtract: effective B = ~in_b, effective cin = 1. in_cin is ignored when in_sub=1.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the carry from stage k-1. Stage 0 uses the effective cin.
  - Registers its CHUNK-bit sum alongside the lower chunks already resolved.
  - Forwards the unconsumed upper chunks of A and B and the new carry.
  - Each stage carries its own valid bit.
- Latency: exactly STAGES cycles from accept edge to out_valid=1, when unstalled. Throughput is 1 op/cycle.
- Ordering: strictly in order. No drops, no duplicates.
- out_cout is the carry from the final chunk:
  - add mode: unsigned overflow.
  - sub mode: 1 means no borrow (A >= B unsigned).
- Arithmetic wraps modulo 2^WIDTH.
- Bubbles: when in_valid=0 at an unstalled edge, a bubble (valid=0) enters stage 0. Bubbles advance normally.
- Simultaneous output consume and input accept in the same cycle is allowed when full; the pipe remains full.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit, reset 0). It is the two's-complement signed overflow of the completed operation: carry into MSB XOR carry out of MSB, computed in the final stage.
  - It is registered, aligned with out_sum, and held during stall.
- Undefined: port absent. No extra logic.

Test Plan (defaults WIDTH=32, STAGES=4):
1. Basic add: in_a=1, in_b=0, in_cin=1, in_sub=0, out_ready=1 -> out_valid=1 exactly 4 cycles after accept, out_sum=2, out_cout=0.
2. Full carry ripple: in_a=FFFFFFFF, in_b=00000001, in_cin=0 -> out_sum=00000000, out_cout=1.
3. Subtract: in_a=5, in_b=7, in_sub=1, in_cin=1 (ignored) -> out_sum=FFFFFFFE, out_cout=0. Then in_a=7, in_b=5 -> out_sum=2, out_cout=1.
4. Streaming: 6 consecutive accepts (k, k+1) for k=0..5, out_ready=1 -> results 1,3,5,7,9,11 on 6 consecutive cycles in order. A bubble inserted after op 3 yields one out_valid=0 cycle at the same position.
5. Stall and reset:
   - Fill the pipe, drop out_ready for 3 cycles -> in_ready=0, out_sum/out_valid held, later inputs ignored. Raise out_ready -> all 4 results emitted once, in order.
   - Then assert rst asynchronously (between edges) with 2 ops in flight -> out_valid/out_sum/out_cout go 0 immediately. No result appears after release.
6. Overflow (PIPELINED_ADDER_OVF_EN defined): in_a=7FFFFFFF, in_b=1, add -> out_sum=80000000, out_ovf=1, out_cout=0. in_a=80000000, in_b=1, sub -> out_ovf=1. in_a=3, in_b=4, add -> out_ovf=0.
